// File: rtl/divu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divu_pkg
//  Description : Shared constants and state encoding for the iterative
//                unsigned/signed divider sequencer (divu_seq).
//  Revision    : 1.0  initial release
// ============================================================================
package divu_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned COUNT_W = 5;

    // Quotient reported on a zero divisor (all ones, i.e. -1)
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DONE  = 3'd2,
        SETUP = 3'd3,
        FIXUP = 3'd4
    } state_t;

endpackage : divu_pkg
`default_nettype wire

// File: rtl/divu_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : divu_sign_fix
//  Description : Conditional two's-complement negate. Used to take operand
//                magnitudes before a signed divide and to restore the result
//                signs afterwards.
//  Revision    : 1.0  initial release
// ============================================================================
module divu_sign_fix
    import divu_pkg::*;
(
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // Negate when requested, otherwise pass through unchanged
    always_comb begin
        o_val = i_neg ? (~i_val + 1'b1) : i_val;
    end

endmodule : divu_sign_fix
`default_nettype wire

// File: rtl/divu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divu_seq
//  Description : Iterative 32-bit restoring divider. One quotient bit per
//                cycle; each trial subtraction is performed by the shared
//                external adder/subtractor through the as_* ports.
//                Optional signed support is enabled by defining the macro
//                DIVU_SEQ_SIGNED_EN (adds is_signed and SETUP/FIXUP states).
//  Revision    : 1.0  initial release
// ============================================================================
module divu_seq
    import divu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVU_SEQ_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_ctl0,
    output logic             as_ctl1,
    input  logic [WIDTH-1:0] as_out,
    input  logic             as_cout
);

    localparam logic [COUNT_W-1:0] c_last_cnt = COUNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rem;
    logic [COUNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_trial;
    logic               w_take;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;

`ifdef DIVU_SEQ_SIGNED_EN
    logic               r_signed;
    logic               r_qneg;     // quotient must be negated (signs differ)
    logic               r_rneg;     // dividend negative: remainder negated
    logic               r_dneg;     // divisor negative
    logic               w_in_setup;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_fix_b_in;
    logic [WIDTH-1:0]   w_fix_a;
    logic [WIDTH-1:0]   w_fix_b;

    // Two shared negators: in SETUP they produce |dividend| and |divisor|,
    // in FIXUP they produce the signed quotient and remainder.
    always_comb begin
        w_in_setup = (r_state == SETUP);
        w_neg_a    = w_in_setup ? r_rneg : r_qneg;
        w_neg_b    = w_in_setup ? r_dneg : r_rneg;
        w_fix_b_in = w_in_setup ? r_d    : r_rem;
    end

    divu_sign_fix u_fix_a (
        .i_val (r_q),
        .i_neg (w_neg_a),
        .o_val (w_fix_a)
    );

    divu_sign_fix u_fix_b (
        .i_val (w_fix_b_in),
        .i_neg (w_neg_b),
        .o_val (w_fix_b)
    );
`endif

    // Trial subtraction drive; idle outside RUN so the shared unit sees zeros
    always_comb begin
        w_trial = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
        as_a    = '0;
        as_b    = '0;
        as_ctl0 = 1'b0;
        as_ctl1 = 1'b0;
        if (r_state == RUN) begin
            as_a    = w_trial;
            as_b    = r_d;
            as_ctl0 = 1'b1;
        end
    end

    // Restoring step: the old remainder MSB acts as the 33rd bit, so a set
    // MSB guarantees the subtraction succeeds and as_out is exact mod 2^32
    always_comb begin
        w_take     = r_rem[WIDTH-1] | as_cout;
        w_rem_next = w_take ? as_out : w_trial;
        w_q_next   = {r_q[WIDTH-2:0], w_take};
    end

    // Sequencer state, operand registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_d         <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVU_SEQ_SIGNED_EN
            r_signed    <= 1'b0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dneg      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_d   <= divisor;
                            r_q   <= dividend;
                            r_rem <= '0;
                            r_cnt <= '0;
`ifdef DIVU_SEQ_SIGNED_EN
                            r_signed <= is_signed;
                            r_qneg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_rneg   <= is_signed & dividend[WIDTH-1];
                            r_dneg   <= is_signed & divisor[WIDTH-1];
                            r_state  <= is_signed ? SETUP : RUN;
`else
                            r_state  <= RUN;
`endif
                        end
                    end
                end

                RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
`ifdef DIVU_SEQ_SIGNED_EN
                        if (r_signed) begin
                            r_state <= FIXUP;
                        end else begin
                            quotient  <= w_q_next;
                            remainder <= w_rem_next;
                            done      <= 1'b1;
                            r_state   <= DONE;
                        end
`else
                        quotient  <= w_q_next;
                        remainder <= w_rem_next;
                        done      <= 1'b1;
                        r_state   <= DONE;
`endif
                    end
                end

`ifdef DIVU_SEQ_SIGNED_EN
                SETUP: begin
                    r_q     <= w_fix_a;
                    r_d     <= w_fix_b;
                    r_state <= RUN;
                end

                FIXUP: begin
                    quotient  <= w_fix_a;
                    remainder <= w_fix_b;
                    done      <= 1'b1;
                    r_state   <= DONE;
                end
`endif

                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : divu_seq
`default_nettype wire
